// File: rtl/td4_prog_loader.sv
// Program memory and byte-stream loader for the TD4 CPU: serves instructions combinationally
// and reloads all 16 words from a checksummed stream while holding the CPU in reset.
module td4_prog_loader #(
  parameter int TIMEOUT = 50000,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] addr,
  output logic [7:0] data,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_byte,
  output logic       ld_ready,
  output logic       cpu_n_reset,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_reg, state_next;
  logic [3:0]       wptr_reg, wptr_next;
  logic [7:0]       sum_reg, sum_next;
  logic [CNT_W-1:0] tcnt_reg, tcnt_next;
  logic             err_reg, err_next;
  logic             cpu_n_reset_reg;
  logic [7:0]       mem_reg [16];
  logic [15:0]      word_we;
  logic             in_load;
  logic             accept;
  logic             wr_en;
  logic             timed_out;

  assign in_load     = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
  assign busy        = in_load;
  assign ld_ready    = in_load & ~ld_start;
  assign accept      = ld_valid & ld_ready;
  assign wr_en       = accept & (state_reg == ST_LOAD);
  assign timed_out   = ~accept & (tcnt_reg == TCNT_LAST);
  assign err         = err_reg;
  assign cpu_n_reset = cpu_n_reset_reg;

  // Asynchronous read: a word written this cycle still reads its old value.
  assign data = mem_reg[addr];

  for (genvar gi = 0; gi < 16; gi++) begin : g_we
    assign word_we[gi] = wr_en & (wptr_reg == 4'(gi));
  end

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    sum_next   = sum_reg;
    tcnt_next  = tcnt_reg;
    err_next   = err_reg;
    if (ld_start) begin
      state_next = ST_LOAD;
      wptr_next  = 4'd0;
      sum_next   = 8'd0;
      tcnt_next  = '0;
      err_next   = 1'b0;
    end else if (in_load) begin
      if (accept) begin
        tcnt_next = '0;
        if (state_reg == ST_LOAD) begin
          wptr_next = wptr_reg + 4'd1;
          sum_next  = sum_reg + ld_byte;
          if (wptr_reg == 4'd15) begin
            state_next = ST_CHECK;
          end
        end else if (ld_byte == sum_reg) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_ERROR;
          err_next   = 1'b1;
        end
      end else if (timed_out) begin
        state_next = ST_ERROR;
        err_next   = 1'b1;
      end else begin
        tcnt_next = tcnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg       <= ST_RUN;
      wptr_reg        <= 4'd0;
      sum_reg         <= 8'd0;
      tcnt_reg        <= '0;
      err_reg         <= 1'b0;
      cpu_n_reset_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wptr_reg        <= wptr_next;
      sum_reg         <= sum_next;
      tcnt_reg        <= tcnt_next;
      err_reg         <= err_next;
      cpu_n_reset_reg <= (state_next == ST_RUN);
    end
  end

  // Memory clears on reset so no partial program survives an aborted load.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_reg[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (word_we[i]) begin
          mem_reg[i] <= ld_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Scoreboard bench for td4_prog_loader: stimulus queues expectations, a negedge monitor
// pops and compares them, and every handshake is checked against an expected-accept queue.
module tb_td4_prog_loader;

  localparam int TIMEOUT = 8;

  localparam logic [2:0] K_DATA  = 3'd0;
  localparam logic [2:0] K_CPUN  = 3'd1;
  localparam logic [2:0] K_BUSY  = 3'd2;
  localparam logic [2:0] K_ERR   = 3'd3;
  localparam logic [2:0] K_READY = 3'd4;
  localparam logic [2:0] K_BOUND = 3'd5;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] a;
    logic [7:0] exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] data;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_byte = 8'h00;
  logic       ld_ready;
  logic       cpu_n_reset;
  logic       busy;
  logic       err;

  chk_t       chk_q[$];
  logic [7:0] acc_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  logic [7:0] prog1 [16] = '{8'h31, 8'h51, 8'h00, 8'hB1, 8'h02, 8'h90, 8'hE3, 8'h7F,
                             8'h40, 8'h05, 8'hC8, 8'h11, 8'hF0, 8'h6A, 8'h23, 8'hBE};
  logic [7:0] prog2 [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                             8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h87};
  logic [7:0] prog3 [16] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                             8'hB8, 8'hB9, 8'hBA, 8'hBB, 8'hBC, 8'hBD, 8'hBE, 8'hBF};
  logic [7:0] tbytes [3] = '{8'h5C, 8'hC5, 8'h77};

  td4_prog_loader #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .addr       (addr),
    .data       (data),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_ready   (ld_ready),
    .cpu_n_reset(cpu_n_reset),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_DATA:  return "data";
      K_CPUN:  return "cpu_n_reset";
      K_BUSY:  return "busy";
      K_ERR:   return "err";
      K_READY: return "ld_ready";
      default: return "handshake_bound";
    endcase
  endfunction

  // Monitor: checks every handshake and every queued expectation at the falling edge.
  chk_t       mon_c;
  logic [7:0] mon_act;
  logic [7:0] mon_b;
  always @(negedge clk) begin
    if (ld_valid && ld_ready) begin
      n_checks++;
      if (acc_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_accept: byte %02h accepted, required no accept", ld_byte);
      end else begin
        mon_b = acc_q.pop_front();
        if (busy !== 1'b1 || cpu_n_reset !== 1'b0) begin
          n_fail++;
          $display("FAIL accept_state byte %02h: busy=%b cpu_n_reset=%b, required busy=1 cpu_n_reset=0",
                   mon_b, busy, cpu_n_reset);
        end else begin
          $display("accept byte %02h busy=1 cpu_n_reset=0 ok", mon_b);
        end
      end
    end
    if (chk_q.size() != 0) begin
      mon_c = chk_q.pop_front();
      case (mon_c.kind)
        K_DATA:  mon_act = data;
        K_CPUN:  mon_act = {7'd0, cpu_n_reset};
        K_BUSY:  mon_act = {7'd0, busy};
        K_ERR:   mon_act = {7'd0, err};
        K_READY: mon_act = {7'd0, ld_ready};
        default: mon_act = 8'h00;
      endcase
      n_checks++;
      if (mon_act !== mon_c.exp) begin
        n_fail++;
        $display("FAIL %s addr=%0d: got %02h, required %02h", kname(mon_c.kind), mon_c.a, mon_act, mon_c.exp);
      end else begin
        $display("check %s addr=%0d value=%02h ok", kname(mon_c.kind), mon_c.a, mon_act);
      end
    end
  end

  // All driver tasks start and end one time unit after a rising edge.
  task automatic chk(input logic [2:0] k, input logic [3:0] a, input logic [7:0] e);
    chk_t c;
    c.kind = k;
    c.a    = a;
    c.exp  = e;
    addr = a;
    chk_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    acc_q.push_back(b);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (acc_q.size() != 0 && n < 50);
    ld_valid = 1'b0;
    if (acc_q.size() != 0) begin
      acc_q.delete();
      chk(K_BOUND, 4'd0, 8'h01);
    end
  endtask

  function automatic logic [7:0] sum_of(input logic [7:0] p [16]);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + p[i];
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    @(posedge clk);
    #1;
    // Reset state, then release between edges
    chk(K_CPUN, 4'd0, 8'h00);
    chk(K_BUSY, 4'd0, 8'h00);
    chk(K_ERR, 4'd0, 8'h00);
    chk(K_READY, 4'd0, 8'h00);
    n_reset = 1'b1;
    chk(K_CPUN, 4'd0, 8'h00);
    chk(K_CPUN, 4'd0, 8'h01);
    for (int i = 0; i < 16; i++) chk(K_DATA, 4'(i), 8'h00);

    // Good load with random gaps
    pulse_start();
    chk(K_BUSY, 4'd0, 8'h01);
    chk(K_CPUN, 4'd0, 8'h00);
    chk(K_ERR, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) send_byte(prog1[i], int'($urandom_range(0, 2)));
    s = sum_of(prog1);
    send_byte(s, int'($urandom_range(0, 2)));
    chk(K_CPUN, 4'd0, 8'h01);
    chk(K_BUSY, 4'd0, 8'h00);
    chk(K_ERR, 4'd0, 8'h00);
    chk(K_READY, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) chk(K_DATA, 4'(i), prog1[i]);

    // Bad checksum
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(prog2[i], int'($urandom_range(0, 2)));
    s = sum_of(prog2) ^ 8'h01;
    send_byte(s, 0);
    chk(K_ERR, 4'd0, 8'h01);
    chk(K_CPUN, 4'd0, 8'h00);
    chk(K_READY, 4'd0, 8'h00);
    chk(K_BUSY, 4'd0, 8'h00);
    ld_valid = 1'b1;
    ld_byte  = 8'hEE;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    chk(K_ERR, 4'd0, 8'h01);
    for (int i = 0; i < 16; i++) chk(K_DATA, 4'(i), prog2[i]);
    pulse_start();
    chk(K_ERR, 4'd0, 8'h00);
    chk(K_BUSY, 4'd0, 8'h01);

    // Timeout after 3 bytes: still loading at tcnt=7, aborted on the 8th idle edge
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(tbytes[i], 0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk(K_BUSY, 4'd0, 8'h01);
    chk(K_BUSY, 4'd0, 8'h01);
    chk(K_ERR, 4'd0, 8'h01);
    chk(K_BUSY, 4'd0, 8'h00);
    chk(K_READY, 4'd0, 8'h00);
    for (int i = 0; i < 3; i++) chk(K_DATA, 4'(i), tbytes[i]);
    chk(K_DATA, 4'd3, prog2[3]);

    // Restart mid-load: the byte offered alongside ld_start must not be taken
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(prog1[i], 0);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'hAA;
    chk(K_READY, 4'd0, 8'h00);
    ld_start = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(prog3[i], int'($urandom_range(0, 1)));
    s = sum_of(prog3);
    send_byte(s, 0);
    chk(K_CPUN, 4'd0, 8'h01);
    chk(K_BUSY, 4'd0, 8'h00);
    chk(K_ERR, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) chk(K_DATA, 4'(i), prog3[i]);

    // Asynchronous reset mid-load, sampled before any further clock edge
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(prog2[i], 0);
    n_reset = 1'b0;
    chk(K_CPUN, 4'd0, 8'h00);
    chk(K_BUSY, 4'd0, 8'h00);
    chk(K_DATA, 4'd0, 8'h00);
    n_reset = 1'b1;
    chk(K_CPUN, 4'd0, 8'h00);
    chk(K_CPUN, 4'd0, 8'h01);
    for (int i = 0; i < 16; i++) chk(K_DATA, 4'(i), 8'h00);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- 16x8 program memory for the TD4 CPU, sitting directly upstream of it.
- Drives the CPU instruction bus `data` combinationally from the CPU's 4-bit `addr`.
- Accepts a framed byte stream (16 program bytes plus 1 checksum byte) on a valid/ready interface, for example from a UART RX.
- Holds the CPU in reset while loading, and releases it only when the checksum is good.

Parameters:
- TIMEOUT, 50000: idle cycles allowed between accepted bytes during a load before the load is aborted; must be ≥2.
- CNT_W, 16: width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- addr  in  4  instruction address from the CPU.
- data  out  8  instruction byte, equal to mem[addr].
- ld_start  in  1  single-cycle request to begin a new load.
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  program or checksum byte.
- ld_ready  out  1  loader accepts ld_byte this cycle.
- cpu_n_reset  out  1  registered active-low reset to the CPU.
- busy  out  1  load in progress.
- err  out  1  last load failed (checksum or timeout); sticky.

Behaviour:
- Reset, asynchronous on n_reset low:
  - All 16 memory words = 8'h00.
  - state = RUN, wptr = 0, sum = 0, tcnt = 0, err = 0.
  - cpu_n_reset = 0.
  - cpu_n_reset rises at the first clk edge after n_reset is released.
- Read path: data = mem[addr], purely combinational, in all states. A read of the word being written in the same cycle returns the old value.
- Handshake:
  - A byte is accepted when ld_valid & ld_ready at a rising clk edge.
  - ld_ready = (state is LOAD or CHECK) & ~ld_start.
  - ld_byte is ignored when it is not accepted.
- States: RUN, LOAD, CHECK, ERROR.
- ld_start, in any state, has priority over everything else. At the next edge it sets:
  - state = LOAD, wptr = 0, sum = 0, tcnt = 0, err = 0.
  - Memory is not cleared.
- LOAD:
  - An accepted byte writes mem[wptr] = ld_byte, sum += ld_byte (mod 256), wptr += 1, tcnt = 0.
  - The byte accepted at wptr = 15 moves the state to CHECK; wptr wraps to 0.
- CHECK:
  - The accepted byte is compared with sum; it is not written to memory.
  - Equal: state = RUN.
  - Not equal: state = ERROR, err = 1.
- Timeout, in LOAD and CHECK:
  - tcnt increments on every cycle without an accepted byte.
  - At the edge where tcnt would reach TIMEOUT: state = ERROR, err = 1.
- ERROR:
  - ld_ready = 0.
  - Memory retains its partial contents.
  - The state is left only via ld_start.
- RUN: ld_ready = 0 and ld_valid is ignored.
- cpu_n_reset is a register loaded with (next_state == RUN).
  - It is low from the edge that enters LOAD.
  - It goes high at the same edge that enters RUN after a good checksum.
- busy = (state is LOAD or CHECK), combinational from state.
- err is registered: set on entry to ERROR, cleared only by ld_start or n_reset.
- Reset mid-load (n_reset asserted during LOAD or CHECK):
  - Immediate return to reset values; memory is cleared.
  - No partial program survives.

Test Plan:
- Reset, then read addr 0..15:
  - data = 8'h00 for every address.
  - cpu_n_reset = 0 during reset and 1 one edge after release.
  - busy = 0, err = 0, ld_ready = 0.
- Good load:
  - Pulse ld_start, then stream bytes 8'h31,8'h51,8'h00,8'hB1,... (16 bytes total), then checksum = their sum mod 256, with random ld_valid gaps.
  - cpu_n_reset = 0 throughout the load, 1 at the checksum-accept edge.
  - busy falls at that edge.
  - Readback of addr 0..15 matches the streamed bytes; err = 0.
- Bad checksum: 16 bytes, then checksum XOR 8'h01 →
  - err = 1, cpu_n_reset stays 0, ld_ready = 0.
  - Further ld_valid is ignored.
  - A new ld_start clears err and busy rises.
- Timeout with TIMEOUT = 8:
  - After 3 accepted bytes, hold ld_valid = 0 for 8 cycles → state ERROR, err = 1.
  - mem[0..2] hold the 3 bytes.
- Restart mid-load:
  - After 5 bytes, pulse ld_start while ld_valid = 1 → that byte is not accepted (ld_ready = 0).
  - Then send 16 new bytes plus a correct checksum → mem[0] equals the first new byte and the state is RUN.
- Asynchronous reset mid-load:
  - Assert n_reset low between clk edges during LOAD → cpu_n_reset = 0 and busy = 0 immediately.
  - After release, all data = 8'h00 and cpu_n_reset = 1 after one edge.
